// File: rtl/display_mux.sv
// display_mux: time-multiplexed driver for a row of common-anode 7-segment hex digits.
//
// Scans one digit at a time, each for SCAN_DIV clock cycles. A new value is staged in a
// pending register and only promoted to the active register on the frame-wrap tick, so a
// frame never mixes digits from two different values.
//
// Parameters:
//   DIGITS    number of digits (1..8)
//   SCAN_DIV  clock cycles each digit stays selected (>= 2)
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous, active-high reset
//   enable      in   1 = scan and drive, 0 = blank everything and freeze the scan state
//   load        in   one-cycle strobe capturing value
//   value       in   packed nibbles, nibble k is digit k, digit 0 rightmost
//   hex         out  segments {g,f,e,d,c,b,a}, active-low
//   digit_sel   out  anode enables, active-low, one-hot-low while driving
//   frame_done  out  one-cycle pulse in the cycle after each frame wrap
//
// Build option:
//   DISPLAY_MUX_LZB_EN  leading-zero blanking (digit 0 is never suppressed)

module display_mux #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  output logic [6:0]            hex,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);
  localparam logic [6:0]       BLANK   = 7'b1111111;

  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_act;
  logic [4*DIGITS-1:0] r_pend;
  logic                r_pend_v;

  logic                w_tick;
  logic                w_wrap;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [3:0]          w_nib;
  logic                w_lzb;
  logic [6:0]          w_seg;

  function automatic logic [6:0] seg_code(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0: code = 7'b1000000;
      4'h1: code = 7'b1111001;
      4'h2: code = 7'b0100100;
      4'h3: code = 7'b0110000;
      4'h4: code = 7'b0011001;
      4'h5: code = 7'b0010010;
      4'h6: code = 7'b0000010;
      4'h7: code = 7'b1111000;
      4'h8: code = 7'b0000000;
      4'h9: code = 7'b0010000;
      4'hA: code = 7'b0001000;
      4'hB: code = 7'b0000011;
      4'hC: code = 7'b1000110;
      4'hD: code = 7'b0100001;
      4'hE: code = 7'b0000110;
      default: code = 7'b0001110;
    endcase
    return code;
  endfunction

  assign w_tick = enable && (r_cnt == CNT_MAX);
  assign w_wrap = w_tick && (r_idx == IDX_MAX);

  always_comb begin
    w_idx_nxt = r_idx;
    if (w_tick) begin
      w_idx_nxt = (r_idx == IDX_MAX) ? '0 : r_idx + IDX_W'(1);
    end
  end

  // Select the nibble for the digit about to be driven. Walking from the top digit down
  // lets the same loop track whether everything above (and including) digit k is zero.
  always_comb begin
    logic w_zero_acc;
    w_nib      = 4'h0;
    w_lzb      = 1'b0;
    w_zero_acc = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_zero_acc = w_zero_acc && (r_act[4*k +: 4] == 4'h0);
      if (w_idx_nxt == IDX_W'(k)) begin
        w_nib = r_act[4*k +: 4];
`ifdef DISPLAY_MUX_LZB_EN
        w_lzb = w_zero_acc && (k != 0);
`else
        w_lzb = 1'b0;
`endif
      end
    end
  end

  assign w_seg = w_lzb ? BLANK : seg_code(w_nib);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_act      <= '0;
      r_pend     <= '0;
      r_pend_v   <= 1'b0;
      hex        <= BLANK;
      digit_sel  <= '1;
      frame_done <= 1'b0;
    end else begin
      if (enable) begin
        r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
        r_idx <= w_idx_nxt;
      end

      if (load) begin
        r_pend <= value;
      end

      // A load coinciding with the wrap goes straight to the active register.
      if (w_wrap) begin
        r_pend_v <= 1'b0;
        if (load) begin
          r_act <= value;
        end else if (r_pend_v) begin
          r_act <= r_pend;
        end
      end else if (load) begin
        r_pend_v <= 1'b1;
      end

      frame_done <= w_wrap;

      if (enable) begin
        // Blank for one cycle while the anodes switch to avoid ghosting.
        hex       <= w_tick ? BLANK : w_seg;
        digit_sel <= ~(DIGITS'(1) << w_idx_nxt);
      end else begin
        hex       <= BLANK;
        digit_sel <= '1;
      end
    end
  end

endmodule

// File: tb/tb_display_mux.sv
module tb_display_mux;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] C0 = 7'b1000000;
  localparam logic [6:0] C1 = 7'b1111001;
  localparam logic [6:0] C2 = 7'b0100100;
  localparam logic [6:0] C3 = 7'b0110000;
  localparam logic [6:0] C4 = 7'b0011001;
  localparam logic [6:0] C5 = 7'b0010010;
  localparam logic [6:0] C6 = 7'b0000010;
  localparam logic [6:0] C7 = 7'b1111000;
  localparam logic [6:0] C8 = 7'b0000000;
  localparam logic [6:0] C9 = 7'b0010000;
  localparam logic [6:0] CA = 7'b0001000;
  localparam logic [6:0] CB = 7'b0000011;
  localparam logic [6:0] CC = 7'b1000110;
  localparam logic [6:0] CD = 7'b0100001;
  localparam logic [6:0] CE = 7'b0000110;
  localparam logic [6:0] CF = 7'b0001110;

  typedef struct packed {
    logic [15:0]       val;
    logic [3:0][6:0]   seg;   // seg[k] = expected code for digit k
  } vec_t;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic [6:0]  hex;
  logic [3:0]  digit_sel;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;

  vec_t tbl [6];
  logic [3:0][6:0] seg_1234, seg_5678, seg_ef01;

  display_mux #(
    .DIGITS   (4),
    .SCAN_DIV (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .value      (value),
    .hex        (hex),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Starts at frame offset 0 (already sampled), ends at offset 15.
  task automatic check_frame(input logic [3:0][6:0] seg, input string tag);
    for (int off = 0; off < 16; off++) begin
      int d;
      logic [3:0] es;
      logic [6:0] eh;
      if (off > 0) step();
      d  = off / 4;
      es = 4'b1111 ^ (4'b0001 << d);
      eh = (off % 4 == 0) ? BL : seg[d];
      chk($sformatf("%s sel off%0d", tag, off), {28'h0, digit_sel}, {28'h0, es});
      chk($sformatf("%s hex off%0d", tag, off), {25'h0, hex}, {25'h0, eh});
      chk($sformatf("%s frame_done off%0d", tag, off), {31'h0, frame_done},
          {31'h0, (off == 0)});
    end
  endtask

  task automatic wait_frame_done(input int budget, input int exp_n, input string tag);
    int  n = 0;
    bit  seen = 1'b0;
    while (n < budget && !seen) begin
      step();
      n++;
      if (frame_done === 1'b1) seen = 1'b1;
    end
    chk($sformatf("%s frame_done seen", tag), {31'h0, seen}, 32'd1);
    chk($sformatf("%s wrap latency", tag), n, exp_n);
  endtask

  initial begin
    seg_1234 = {C1, C2, C3, C4};
    seg_5678 = {C5, C6, C7, C8};
    seg_ef01 = {CE, CF, C0, C1};

    tbl[0].val = 16'h89AB; tbl[0].seg = {C8, C9, CA, CB};
    tbl[1].val = 16'h3001; tbl[1].seg = {C3, C0, C0, C1};
`ifdef DISPLAY_MUX_LZB_EN
    tbl[2].val = 16'h0050; tbl[2].seg = {BL, BL, C5, C0};
    tbl[3].val = 16'h0F00; tbl[3].seg = {BL, CF, C0, C0};
    tbl[4].val = 16'h0000; tbl[4].seg = {BL, BL, BL, C0};
`else
    tbl[2].val = 16'h0050; tbl[2].seg = {C0, C0, C5, C0};
    tbl[3].val = 16'h0F00; tbl[3].seg = {C0, CF, C0, C0};
    tbl[4].val = 16'h0000; tbl[4].seg = {C0, C0, C0, C0};
`endif
    tbl[5].val = 16'hCDEF; tbl[5].seg = {CC, CD, CE, CF};

    reset  = 1'b1;
    enable = 1'b0;
    load   = 1'b0;
    value  = 16'h0;
    repeat (2) step();
    chk("reset hex", {25'h0, hex}, {25'h0, BL});
    chk("reset sel", {28'h0, digit_sel}, 32'hF);
    chk("reset frame_done", {31'h0, frame_done}, 32'd0);

    // Release reset, enable, and load 1234 in the first cycle.
    reset  = 1'b0;
    enable = 1'b1;
    load   = 1'b1;
    value  = 16'h1234;
    step();
    load = 1'b0;
    chk("first edge sel", {28'h0, digit_sel}, 32'hE);
    chk("first edge hex", {25'h0, hex}, {25'h0, C0});
    chk("first edge frame_done", {31'h0, frame_done}, 32'd0);
    wait_frame_done(20, 15, "v1234");
    check_frame(seg_1234, "v1234");

    // Load on the exact wrap-tick cycle (offset 15 -> next edge is the wrap).
    load  = 1'b1;
    value = 16'h5678;
    step();
    load = 1'b0;
    check_frame(seg_5678, "v5678 wrapload");

    // Table vectors: load mid-frame, expect them on the following frame.
    for (int i = 0; i < 6; i++) begin
      repeat (6) step();
      load  = 1'b1;
      value = tbl[i].val;
      step();
      load = 1'b0;
      wait_frame_done(20, 10, $sformatf("tbl%0d", i));
      check_frame(tbl[i].seg, $sformatf("tbl%0d", i));
    end

    // Two loads in one frame: last wins, active value holds mid-frame.
    repeat (3) step();
    load  = 1'b1;
    value = 16'hABCD;
    step();
    load = 1'b0;
    repeat (2) step();
    chk("midframe hold d1", {25'h0, hex}, {25'h0, tbl[5].seg[1]});
    repeat (3) step();
    load  = 1'b1;
    value = 16'hEF01;
    step();
    load = 1'b0;
    step();
    chk("midframe hold d2", {25'h0, hex}, {25'h0, tbl[5].seg[2]});
    wait_frame_done(20, 6, "vEF01");
    check_frame(seg_ef01, "vEF01");

    // Pause mid-digit 0 (after its third cycle) for 10 cycles.
    repeat (3) step();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("paused hex %0d", i), {25'h0, hex}, {25'h0, BL});
      chk($sformatf("paused sel %0d", i), {28'h0, digit_sel}, 32'hF);
    end
    enable = 1'b1;
    step();
    chk("resume sel", {28'h0, digit_sel}, 32'hE);
    chk("resume hex", {25'h0, hex}, {25'h0, C1});
    step();
    chk("resume tick sel", {28'h0, digit_sel}, 32'hD);
    chk("resume tick hex", {25'h0, hex}, {25'h0, BL});
    wait_frame_done(20, 12, "resume");
    check_frame(seg_ef01, "after pause");

    // Reset mid-frame with a pending load.
    repeat (5) step();
    load  = 1'b1;
    value = 16'h9999;
    step();
    load = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async reset hex", {25'h0, hex}, {25'h0, BL});
    chk("async reset sel", {28'h0, digit_sel}, 32'hF);
    chk("async reset frame_done", {31'h0, frame_done}, 32'd0);
    step();
    chk("held reset sel", {28'h0, digit_sel}, 32'hF);
    reset = 1'b0;
    step();
    chk("post reset sel", {28'h0, digit_sel}, 32'hE);
    chk("post reset hex", {25'h0, hex}, {25'h0, C0});
    wait_frame_done(20, 15, "post reset");
    check_frame(tbl[4].seg, "post reset f1");
    wait_frame_done(20, 1, "post reset f2");
    check_frame(tbl[4].seg, "post reset f2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
